// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution sequencer: hazard stall, comparator sampling, PC redirect / IF-ID flush, watchdog.
// Optional perf counters are built only when BRANCH_PERF_EN is defined; otherwise perf_* read 0.
module branch_resolve_ctrl #(
  parameter int N         = 32,
  parameter int STALL_MAX = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_stall,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic [N-1:0]     id_target,
  input  logic             hz_ex_alu,
  input  logic             hz_ex_load,
  input  logic             hz_mem_load,
  input  logic             cmp_equal,
  output logic             stall,
  output logic             bubble_ex,
  output logic             pc_src,
  output logic [N-1:0]     pc_target,
  output logic             flush_if,
  output logic             err,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_taken,
  output logic [CNT_W-1:0] perf_stalls
);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STALL_MAX);

  typedef enum logic [1:0] {IDLE, STALL, HOLD} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] scnt, scnt_nxt;
  logic          err_q;
  logic          br, hz, stall_c, bubble_c, res_c, wd, taken;

  assign br    = id_valid & id_branch;
  assign hz    = hz_ex_alu | hz_ex_load | hz_mem_load;
  assign taken = res_c & cmp_equal;

  always_comb begin
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    res_c     = 1'b0;
    wd        = 1'b0;
    state_nxt = state;
    scnt_nxt  = scnt;
    case (state)
      IDLE: begin
        if (br) begin
          if (hz) begin
            stall_c   = 1'b1;
            bubble_c  = 1'b1;
            scnt_nxt  = SW'(1);
            state_nxt = STALL;
          end else begin
            res_c     = 1'b1;
            state_nxt = cmp_equal ? HOLD : IDLE;
          end
        end
      end
      STALL: begin
        if (hz && scnt < SMAX) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          scnt_nxt = scnt + SW'(1);
        end else begin
          // Watchdog: give up waiting and resolve with whatever the comparator says now.
          wd        = hz;
          res_c     = 1'b1;
          scnt_nxt  = '0;
          state_nxt = cmp_equal ? HOLD : IDLE;
        end
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall     = ~rst & stall_c;
  assign bubble_ex = ~rst & ~ext_stall & bubble_c;
  assign pc_src    = ~rst & ~ext_stall & taken;
  assign flush_if  = pc_src;
  assign pc_target = pc_src ? id_target : '0;
  assign err       = ~rst & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scnt  <= '0;
      err_q <= 1'b0;
    end else if (!ext_stall) begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      if (wd) err_q <= 1'b1;
    end
  end

`ifdef BRANCH_PERF_EN
  logic [CNT_W-1:0] cnt_br, cnt_tk, cnt_st;

  // Saturating counters, frozen under ext_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_br <= '0;
      cnt_tk <= '0;
      cnt_st <= '0;
    end else if (!ext_stall) begin
      if (res_c   && cnt_br != '1) cnt_br <= cnt_br + CNT_W'(1);
      if (taken   && cnt_tk != '1) cnt_tk <= cnt_tk + CNT_W'(1);
      if (stall_c && cnt_st != '1) cnt_st <= cnt_st + CNT_W'(1);
    end
  end

  assign perf_branches = rst ? '0 : cnt_br;
  assign perf_taken    = rst ? '0 : cnt_tk;
  assign perf_stalls   = rst ? '0 : cnt_st;
`else
  assign perf_branches = '0;
  assign perf_taken    = '0;
  assign perf_stalls   = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: inputs driven on the falling edge, outputs checked 1ns later.
module tb_branch_resolve_ctrl;
  logic        clk = 1'b0;
  logic        rst, ext_stall, id_valid, id_branch;
  logic [31:0] id_target;
  logic        hz_ex_alu, hz_ex_load, hz_mem_load, cmp_equal;
  logic        stall, bubble_ex, pc_src, flush_if, err;
  logic [31:0] pc_target;
  logic [15:0] perf_branches, perf_taken, perf_stalls;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.N(32), .STALL_MAX(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid), .id_branch(id_branch),
    .id_target(id_target), .hz_ex_alu(hz_ex_alu), .hz_ex_load(hz_ex_load), .hz_mem_load(hz_mem_load),
    .cmp_equal(cmp_equal), .stall(stall), .bubble_ex(bubble_ex), .pc_src(pc_src),
    .pc_target(pc_target), .flush_if(flush_if), .err(err), .perf_branches(perf_branches),
    .perf_taken(perf_taken), .perf_stalls(perf_stalls)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ex, input logic br, input logic [31:0] tgt,
                       input logic alu, input logic eld, input logic mld, input logic cmp);
    @(negedge clk);
    rst = r; ext_stall = ex; id_valid = br; id_branch = br; id_target = tgt;
    hz_ex_alu = alu; hz_ex_load = eld; hz_mem_load = mld; cmp_equal = cmp;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic s, input logic b, input logic p,
                         input logic [31:0] t, input logic f, input logic e);
    chk({tag, ".stall"},     32'(stall),     32'(s));
    chk({tag, ".bubble_ex"}, 32'(bubble_ex), 32'(b));
    chk({tag, ".pc_src"},    32'(pc_src),    32'(p));
    chk({tag, ".pc_target"}, pc_target,      t);
    chk({tag, ".flush_if"},  32'(flush_if),  32'(f));
    chk({tag, ".err"},       32'(err),       32'(e));
  endtask

  task automatic chk_perf(input string tag, input int nb, input int nt, input int ns);
`ifdef BRANCH_PERF_EN
    chk({tag, ".perf_branches"}, 32'(perf_branches), 32'(nb));
    chk({tag, ".perf_taken"},    32'(perf_taken),    32'(nt));
    chk({tag, ".perf_stalls"},   32'(perf_stalls),   32'(ns));
`else
    chk({tag, ".perf_branches"}, 32'(perf_branches), 32'(nb - nb));
    chk({tag, ".perf_taken"},    32'(perf_taken),    32'(nt - nt));
    chk({tag, ".perf_stalls"},   32'(perf_stalls),   32'(ns - ns));
`endif
  endtask

  initial begin
    rst = 1'b1; ext_stall = 1'b0; id_valid = 1'b0; id_branch = 1'b0; id_target = '0;
    hz_ex_alu = 1'b0; hz_ex_load = 1'b0; hz_mem_load = 1'b0; cmp_equal = 1'b0;

    // Reset: outputs forced low even with a taken branch presented
    drive(1, 0, 1, 32'h40, 0, 0, 0, 1); chk_out("rst", 0, 0, 0, 0, 0, 0);
    chk_perf("rst", 0, 0, 0);

    // No-hazard taken, then HOLD ignores the branch
    drive(0, 0, 1, 32'h40, 0, 0, 0, 1); chk_out("t1_taken", 0, 0, 1, 32'h40, 1, 0);
    drive(0, 0, 1, 32'h44, 0, 0, 0, 1); chk_out("t1_hold", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h48, 0, 0, 0, 0); chk_out("nt_idle", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h4c, 0, 0, 0, 1); chk_out("nt_then_taken", 0, 0, 1, 32'h4c, 1, 0);
    drive(0, 0, 0, 32'h0,  0, 0, 0, 0); chk_out("hold2", 0, 0, 0, 0, 0, 0);

    // Hazard for two cycles, resolves taken
    drive(0, 0, 1, 32'h50, 0, 1, 0, 1); chk_out("hz_tk_s1", 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h50, 0, 1, 0, 1); chk_out("hz_tk_s2", 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h50, 0, 0, 0, 1); chk_out("hz_tk_res", 0, 0, 1, 32'h50, 1, 0);
    drive(0, 0, 0, 32'h0,  0, 0, 0, 0); chk_out("hz_tk_hold", 0, 0, 0, 0, 0, 0);
    chk_perf("perf", 4, 3, 2);

    // Hazard for two cycles, resolves not taken, back in IDLE
    drive(0, 0, 1, 32'h60, 0, 1, 0, 0); chk_out("t2_s1", 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h60, 0, 1, 0, 0); chk_out("t2_s2", 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h60, 0, 0, 0, 0); chk_out("t2_res", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h64, 0, 0, 0, 1); chk_out("t2_idle", 0, 0, 1, 32'h64, 1, 0);
    drive(0, 0, 0, 32'h0,  0, 0, 0, 0); chk_out("t2_hold", 0, 0, 0, 0, 0, 0);

    // Stuck hazard: watchdog fires after STALL_MAX stall cycles
    drive(0, 0, 1, 32'h70, 1, 0, 0, 1); chk_out("t3_s1", 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h70, 1, 0, 0, 1); chk_out("t3_s2", 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h70, 1, 0, 0, 1); chk_out("t3_s3", 1, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h70, 1, 0, 0, 1); chk_out("t3_wd", 0, 0, 1, 32'h70, 1, 0);
    drive(0, 0, 1, 32'h74, 1, 0, 0, 1); chk_out("t3_hold", 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 32'h0,  0, 0, 0, 0); chk_out("t3_sticky", 0, 0, 0, 0, 0, 1);

    // ext_stall freezes a STALL mid-count
    drive(0, 0, 1, 32'h80, 0, 0, 1, 0); chk_out("t4_s1", 1, 1, 0, 0, 0, 1);
    drive(0, 1, 1, 32'h80, 0, 0, 1, 1); chk_out("t4_ext1", 1, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 32'h80, 0, 0, 1, 1); chk_out("t4_ext2", 1, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 32'h80, 0, 0, 1, 1); chk_out("t4_s2", 1, 1, 0, 0, 0, 1);
    drive(0, 0, 1, 32'h80, 0, 0, 1, 1); chk_out("t4_s3", 1, 1, 0, 0, 0, 1);
    drive(0, 0, 1, 32'h80, 0, 0, 1, 1); chk_out("t4_wd", 0, 0, 1, 32'h80, 1, 1);
    drive(0, 0, 0, 32'h0,  0, 0, 0, 0); chk_out("t4_hold", 0, 0, 0, 0, 0, 1);

    // Reset mid-STALL with err set
    drive(0, 0, 1, 32'h90, 0, 1, 0, 0); chk_out("t5_s1", 1, 1, 0, 0, 0, 1);
    drive(1, 0, 1, 32'h90, 0, 1, 0, 1); chk_out("t5_rst", 0, 0, 0, 0, 0, 0);
    chk_perf("t5_rst", 0, 0, 0);
    drive(0, 0, 0, 32'h90, 0, 0, 0, 1); chk_out("t5_idle", 0, 0, 0, 0, 0, 0);
    chk_perf("t5_after", 0, 0, 0);
    drive(0, 0, 1, 32'h94, 0, 0, 0, 1); chk_out("t5_branch", 0, 0, 1, 32'h94, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
